// File: rtl/neuron_pkg.sv
// Shared types, default widths and activation bound helpers for the neuron output accumulator.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ACT   = 2'd2
    } state_t;

    localparam int DEF_N_INPUTS = 16;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WEIGHT_W = 8;
    localparam int DEF_BIAS_W   = 16;
    localparam int DEF_ACC_W    = 24;
    localparam int DEF_SHIFT    = 4;
    localparam int DEF_OUT_W    = 9;

    // Beat counter must be at least one bit wide even for single-beat jobs.
    function automatic int count_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int relu_max(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int RELU_MAX = relu_max(DEF_OUT_W);
    localparam int SAT_MAX  = sat_max(DEF_OUT_W);
    localparam int SAT_MIN  = sat_min(DEF_OUT_W);

endpackage

// File: rtl/neuron_activation_sat.sv
// Fixed-point rescale and output activation: ReLU with unsigned clamp when NEURON_RELU_EN
// is defined, otherwise signed saturation to the OUT_W two's-complement range.
module neuron_activation_sat
    import neuron_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] result
);

    logic signed [ACC_W-1:0] s;

    assign s = acc >>> SHIFT;

`ifdef NEURON_RELU_EN
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(relu_max(OUT_W));

    always_comb begin
        result = s[OUT_W-1:0];
        if (s < 0)
            result = '0;
        else if (s > HI)
            result = '1;
    end
`else
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_max(OUT_W));
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_min(OUT_W));

    always_comb begin
        result = s[OUT_W-1:0];
        if (s > HI)
            result = HI[OUT_W-1:0];
        else if (s < LO)
            result = LO[OUT_W-1:0];
    end
`endif

endmodule

// File: rtl/neuron_output_accumulator.sv
// One output neuron per job: bias + sum of N_INPUTS signed products, then rescale and activation.
// Activation mode is selected by the NEURON_RELU_EN macro (see neuron_activation_sat).
module neuron_output_accumulator
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int BIAS_W   = DEF_BIAS_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [BIAS_W-1:0]   bias,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic signed [WEIGHT_W-1:0] in_weight,
    output logic                       busy,
    output logic                       done,
    output logic        [OUT_W-1:0]    out_data
);

    localparam int                COUNT_W = count_w(N_INPUTS);
    localparam logic [COUNT_W-1:0] LAST   = COUNT_W'(N_INPUTS - 1);

    state_t                            state;
    logic signed [ACC_W-1:0]           acc;
    logic        [COUNT_W-1:0]         count;
    logic signed [DATA_W+WEIGHT_W-1:0] prod;
    logic        [OUT_W-1:0]           act_val;

    assign prod = in_data * in_weight;

    neuron_activation_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_act (
        .acc    (acc),
        .result (act_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_data <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= ACC_W'(bias);
                        count    <= '0;
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= acc + ACC_W'(prod);
                        if (count == LAST) begin
                            count    <= '0;
                            state    <= ACT;
                            in_ready <= 1'b0;
                        end else begin
                            count <= count + COUNT_W'(1);
                        end
                    end
                end
                ACT: begin
                    // acc is final here; the result lands together with the done pulse.
                    out_data <= act_val;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_output_accumulator.sv
// Self-checking bench: two DUTs (SHIFT=0 and SHIFT=4, N_INPUTS=4) share stimulus and are
// compared against a plain-arithmetic model of bias + dot product, shift and activation.
module tb_neuron_output_accumulator;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] bias;
    logic               in_valid;
    logic signed [7:0]  in_data;
    logic signed [7:0]  in_weight;
    logic               in_ready0, busy0, done0;
    logic               in_ready1, busy1, done1;
    logic [8:0]         out0, out1;
    logic [8:0]         hold0, hold1;
    int                 checks = 0;
    int                 failures = 0;

    always #5 clk = ~clk;

    neuron_output_accumulator #(.N_INPUTS(N), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_weight(in_weight),
        .busy(busy0), .done(done0), .out_data(out0)
    );

    neuron_output_accumulator #(.N_INPUTS(N), .SHIFT(4)) dut1 (
        .clk(clk), .reset(reset), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_weight(in_weight),
        .busy(busy1), .done(done1), .out_data(out1)
    );

    function automatic logic [8:0] act_ref(input int sum, input int sh);
        int s;
        int r;
        logic [31:0] u;
        s = sum >>> sh;
`ifdef NEURON_RELU_EN
        r = (s < 0) ? 0 : ((s > 511) ? 511 : s);
`else
        r = (s < -256) ? -256 : ((s > 255) ? 255 : s);
`endif
        u = r;
        return u[8:0];
    endfunction

    // mode 0: in_valid held high, 1: pattern 1,0,0,1..., 2: random gaps
    task automatic run_job(input string name, input int b, input int d[N], input int w[N],
                           input int mode, input bit stray);
        int sum, idx, k;
        bit v, acc_now;
        logic [8:0] e0, e1;
        sum = b;
        for (int i = 0; i < N; i++) sum += d[i] * w[i];
        e0 = act_ref(sum, 0);
        e1 = act_ref(sum, 4);
        @(negedge clk);
        start = 1'b1;
        bias  = 16'(b);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start: got %b/%b want 1/1", name, busy0, busy1);
        end
        idx = 0;
        k = 0;
        while (idx < N) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid  = v;
            in_data   = 8'(d[idx]);
            in_weight = 8'(w[idx]);
            start     = stray && (k == 1);
            checks++;
            if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1 || done0 !== 1'b0 || done1 !== 1'b0 ||
                out0 !== hold0 || out1 !== hold1) begin
                failures++;
                $display("FAIL %s accum_cycle%0d: rdy=%b/%b done=%b/%b out=%0h/%0h want rdy=1 done=0 out=%0h/%0h",
                         name, k, in_ready0, in_ready1, done0, done1, out0, out1, hold0, hold1);
            end
            acc_now = v && in_ready0;
            @(negedge clk);
            if (acc_now) idx++;
            k++;
            if (k > 100) begin
                failures++;
                $display("FAIL %s beat_timeout: accepted %0d want %0d", name, idx, N);
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if (done0 !== 1'b0 || in_ready0 !== 1'b0 || busy0 !== 1'b1 ||
            done1 !== 1'b0 || in_ready1 !== 1'b0 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL %s act_cycle: done=%b/%b rdy=%b/%b busy=%b/%b want done=0 rdy=0 busy=1",
                     name, done0, done1, in_ready0, in_ready1, busy0, busy1);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || out0 !== e0 || out1 !== e1 ||
            busy0 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL %s result: done=%b/%b out=%0h/%0h busy=%b/%b want done=1 out=%0h/%0h busy=0",
                     name, done0, done1, out0, out1, busy0, busy1, e0, e1);
        end
        hold0 = e0;
        hold1 = e1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0 ||
                out0 !== hold0 || out1 !== hold1) begin
                failures++;
                $display("FAIL %s after_done%0d: done=%b/%b busy=%b/%b out=%0h/%0h want done=0 busy=0 out=%0h/%0h",
                         name, c, done0, done1, busy0, busy1, out0, out1, hold0, hold1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0; in_data = '0; in_weight = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || out0 !== 9'd0 ||
            in_ready1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || out1 !== 9'd0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b/%b busy=%b/%b done=%b/%b out=%0h/%0h want all 0",
                     in_ready0, in_ready1, busy0, busy1, done0, done1, out0, out1);
        end
        reset = 1'b0;
        hold0 = '0;
        hold1 = '0;
    endtask

    task automatic test_idle_stray();
        in_valid = 1'b1; in_data = 8'sd100; in_weight = 8'sd100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
                failures++;
                $display("FAIL idle_stray%0d: rdy=%b/%b busy=%b done=%b want 0", c,
                         in_ready0, in_ready1, busy0, done0);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; bias = 16'sd50;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'sd7; in_weight = 8'sd9;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || in_ready0 !== 1'b0 || done0 !== 1'b0 ||
            out0 !== 9'd0 || out1 !== 9'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b/%b rdy=%b done=%b out=%0h/%0h want 0",
                     busy0, busy1, in_ready0, done0, out0, out1);
        end
        hold0 = '0;
        hold1 = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (done0 !== 1'b0 || done1 !== 1'b0 || out0 !== 9'd0) begin
                failures++;
                $display("FAIL reset_mid_nodone%0d: done=%b/%b out=%0h want done=0 out=0",
                         c, done0, done1, out0);
            end
        end
    endtask

    task automatic test_random();
        int d[N];
        int w[N];
        int b;
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < N; i++) begin
                d[i] = int'($urandom_range(0, 255)) - 128;
                w[i] = int'($urandom_range(0, 255)) - 128;
            end
            b = int'($urandom_range(0, 65535)) - 32768;
            run_job("random", b, d, w, 2, j[0]);
        end
    endtask

    initial begin
        int d[N];
        int w[N];
        test_reset();
        d = '{10, 20, 30, 40};     w = '{1, 2, 3, 4};
        run_job("basic", 0, d, w, 0, 1'b0);
        d = '{100, 100, 100, 100}; w = '{100, 100, 100, 100};
        run_job("saturate", 0, d, w, 0, 1'b0);
        d = '{-10, -10, -10, -10}; w = '{5, 5, 5, 5};
        run_job("negative", 0, d, w, 0, 1'b0);
        d = '{8, 8, 8, 8};         w = '{4, 4, 4, 4};
        run_job("bias_shift", -16, d, w, 0, 1'b0);
        d = '{10, 20, 30, 40};     w = '{1, 2, 3, 4};
        run_job("backpressure", 0, d, w, 1, 1'b0);
        run_job("stray_start", 0, d, w, 0, 1'b1);
        test_idle_stray();
        d = '{-128, 127, -128, 127}; w = '{-128, -128, 127, 127};
        run_job("after_idle_stray", 1234, d, w, 0, 1'b0);
        test_reset_mid();
        d = '{8, 8, 8, 8};         w = '{4, 4, 4, 4};
        run_job("fresh_after_reset", -16, d, w, 1, 1'b0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
